// File: rtl/actuated_signal_scheduler.sv
// Demand-actuated phase scheduler for a two-approach intersection with a
// pedestrian walk interval. Greens are held between a minimum and a maximum
// (the maximum only applies while conflicting demand exists). Yellow, all-red
// and walk are fixed-length timed phases. Lamps are decoded from the state
// register only, so no input reaches an output without passing a flop.
module actuated_signal_scheduler #(
  parameter int MIN_GREEN = 1000,
  parameter int MAX_GREEN = 6000,
  parameter int YELLOW    = 500,
  parameter int ALL_RED   = 100,
  parameter int WALK      = 700,
  parameter int CNT_W     = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       veh1_req,
  input  logic       veh2_req,
  input  logic       ped_req,
  output logic       light1_green,
  output logic       light1_yellow,
  output logic       light1_red,
  output logic       light2_green,
  output logic       light2_yellow,
  output logic       light2_red,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_G1   = 3'd0,
    S_Y1   = 3'd1,
    S_AR1  = 3'd2,
    S_G2   = 3'd3,
    S_Y2   = 3'd4,
    S_AR2  = 3'd5,
    S_WALK = 3'd6
  } state_t;

  // Last counter value of each phase (counter runs 0 .. N-1).
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK - 1);

  state_t           state;
  state_t           state_nxt;
  state_t           next_g;
  state_t           next_g_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ped_nxt;
  logic             in_green;
  logic             entering_walk;

  assign in_green      = (state == S_G1) || (state == S_G2);
  assign entering_walk = (state_nxt == S_WALK) && (state != S_WALK);

  // Next-state selection: greens exit on demand within min/max limits,
  // timed phases exit when their counter reaches the last cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_G1: begin
        if ((cnt >= MIN_LAST) && (veh2_req || ped_pending) &&
            (!veh1_req || (cnt == MAX_LAST)))
          state_nxt = S_Y1;
      end
      S_Y1: begin
        if (cnt == YELLOW_LAST)
          state_nxt = S_AR1;
      end
      S_AR1: begin
        if (cnt == AR_LAST)
          state_nxt = ped_pending ? S_WALK : S_G2;
      end
      S_G2: begin
        if ((cnt >= MIN_LAST) && (veh1_req || ped_pending) &&
            (!veh2_req || (cnt == MAX_LAST)))
          state_nxt = S_Y2;
      end
      S_Y2: begin
        if (cnt == YELLOW_LAST)
          state_nxt = S_AR2;
      end
      S_AR2: begin
        if (cnt == AR_LAST)
          state_nxt = ped_pending ? S_WALK : S_G1;
      end
      S_WALK: begin
        if (cnt == WALK_LAST)
          state_nxt = next_g;
      end
      default: state_nxt = S_G1;
    endcase
  end

  // Counter, return-green memory and pedestrian latch next values.
  always_comb begin
    next_g_nxt = next_g;
    cnt_nxt    = cnt + 1'b1;
    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state_nxt == S_AR1)
        next_g_nxt = S_G2;
      else if (state_nxt == S_AR2)
        next_g_nxt = S_G1;
    end else if (in_green && (cnt == MAX_LAST)) begin
      cnt_nxt = cnt;
    end
    // Clearing on walk entry takes priority over a simultaneous press.
    ped_nxt = entering_walk ? 1'b0 : (ped_pending || ped_req);
  end

  // State, counter and latch registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_G1;
      next_g      <= S_G2;
      cnt         <= '0;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      next_g      <= next_g_nxt;
      cnt         <= cnt_nxt;
      ped_pending <= ped_nxt;
    end
  end

  // Moore lamp decode; all-red, walk and any illegal code show both reds.
  always_comb begin
    light1_green  = 1'b0;
    light1_yellow = 1'b0;
    light1_red    = 1'b0;
    light2_green  = 1'b0;
    light2_yellow = 1'b0;
    light2_red    = 1'b0;
    walk          = (state == S_WALK);
    phase         = state;
    case (state)
      S_G1: begin
        light1_green = 1'b1;
        light2_red   = 1'b1;
      end
      S_Y1: begin
        light1_yellow = 1'b1;
        light2_red    = 1'b1;
      end
      S_G2: begin
        light2_green = 1'b1;
        light1_red   = 1'b1;
      end
      S_Y2: begin
        light2_yellow = 1'b1;
        light1_red    = 1'b1;
      end
      default: begin
        light1_red = 1'b1;
        light2_red = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_actuated_signal_scheduler.sv
// Scoreboard bench for actuated_signal_scheduler: a phase/elapsed-time model
// predicts the visible lamps after every edge; a monitor checks them.
module tb_actuated_signal_scheduler;

  localparam int MIN_G = 4;
  localparam int MAX_G = 10;
  localparam int YEL   = 3;
  localparam int ARD   = 2;
  localparam int WLK   = 5;
  localparam int CW    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       veh1_req, veh2_req, ped_req;
  logic       light1_green, light1_yellow, light1_red;
  logic       light2_green, light2_yellow, light2_red;
  logic       walk, ped_pending;
  logic [2:0] phase;

  always #5 clk = ~clk;

  actuated_signal_scheduler #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW(YEL),
    .ALL_RED(ARD), .WALK(WLK), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .veh1_req(veh1_req), .veh2_req(veh2_req), .ped_req(ped_req),
    .light1_green(light1_green), .light1_yellow(light1_yellow),
    .light1_red(light1_red), .light2_green(light2_green),
    .light2_yellow(light2_yellow), .light2_red(light2_red),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  typedef struct packed {
    logic [2:0] ph;
    logic [7:0] lamps;  // g1 y1 r1 g2 y2 r2 walk ped_pending
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_ev;

  // Reference model: phase number, cycles elapsed in it, return green, latch.
  int m_ph, m_t, m_next;
  bit m_ped;

  function automatic void model_reset();
    m_ph = 0; m_t = 0; m_next = 3; m_ped = 1'b0;
  endfunction

  function automatic int dur_of(int ph);
    case (ph)
      1, 4:    return YEL;
      2, 5:    return ARD;
      6:       return WLK;
      default: return 0;
    endcase
  endfunction

  function automatic void model_step(bit v1, bit v2, bit p);
    int nph;
    bit own, other;
    int served;
    nph = m_ph;
    if (m_ph == 0 || m_ph == 3) begin
      own    = (m_ph == 0) ? v1 : v2;
      other  = (m_ph == 0) ? v2 : v1;
      served = m_t + 1;
      if (served >= MIN_G && (other || m_ped) && (!own || served >= MAX_G))
        nph = m_ph + 1;
    end else if (m_t + 1 == dur_of(m_ph)) begin
      case (m_ph)
        1:       nph = 2;
        4:       nph = 5;
        2:       nph = m_ped ? 6 : 3;
        5:       nph = m_ped ? 6 : 0;
        default: nph = m_next;
      endcase
    end
    if (nph != m_ph && nph == 2) m_next = 3;
    if (nph != m_ph && nph == 5) m_next = 0;
    if (nph == 6 && m_ph != 6) m_ped = 1'b0;
    else                       m_ped = m_ped | p;
    m_t  = (nph != m_ph) ? 0 : m_t + 1;
    m_ph = nph;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit g1, y1, g2, y2;
    g1 = (m_ph == 0); y1 = (m_ph == 1);
    g2 = (m_ph == 3); y2 = (m_ph == 4);
    e.ph    = 3'(m_ph);
    e.lamps = {g1, y1, !(g1 || y1), g2, y2, !(g2 || y2), (m_ph == 6), m_ped};
    return e;
  endfunction

  // Monitor: pops one expectation per presented output and compares.
  always @(negedge clk or chk_ev) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e   = sb.pop_front();
      got = {light1_green, light1_yellow, light1_red, light2_green,
             light2_yellow, light2_red, walk, ped_pending};
      n_cmp++;
      if (phase !== e.ph) begin
        n_bad++;
        $display("FAIL phase @%0t got %0d want %0d", $time, phase, e.ph);
      end
      n_cmp++;
      if (got !== e.lamps) begin
        n_bad++;
        $display("FAIL lamps @%0t got %b want %b", $time, got, e.lamps);
      end
      n_cmp++;
      if (!$onehot({light1_green, light1_yellow, light1_red}) ||
          !$onehot({light2_green, light2_yellow, light2_red})) begin
        n_bad++;
        $display("FAIL one_lamp @%0t got %b want one-hot per approach", $time, got[7:2]);
      end
    end
  end

  // One clock: model consumes the inputs sampled at this edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step(veh1_req, veh2_req, ped_req);
    sb.push_back(expect_now());
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asserts reset between edges and checks the outputs before any edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    sb.push_back(expect_now());
    -> chk_ev;
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_phase(int ph, int budget, string name);
    int k;
    k = 0;
    while (m_ph != ph && k < budget) begin
      tick();
      k++;
    end
    if (m_ph != ph) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout got phase %0d want %0d", name, m_ph, ph);
    end
  endtask

  initial begin
    int ped_left;
    rst = 1'b0; veh1_req = 1'b0; veh2_req = 1'b0; ped_req = 1'b0;
    model_reset();
    #2;
    sb.push_back(expect_now());
    -> chk_ev;
    ticks(2);
    rst = 1'b1;

    // Rest in G1 without demand.
    ticks(50);

    // Gap-out to G2, then rest there.
    do_reset();
    veh2_req = 1'b1;
    ticks(25);
    veh2_req = 1'b0;

    // Max-out with both approaches demanding.
    do_reset();
    veh1_req = 1'b1; veh2_req = 1'b1;
    ticks(45);
    veh1_req = 1'b0; veh2_req = 1'b0;

    // Pedestrian pulse at cycle 1 with no vehicle demand.
    do_reset();
    tick();
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    ticks(30);

    // Re-latch during WALK; second walk follows AR2.
    do_reset();
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    wait_phase(6, 40, "walk_entry");
    tick();
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    ticks(40);

    // Asynchronous reset during Y2.
    do_reset();
    veh2_req = 1'b1;
    wait_phase(3, 60, "reach_g2");
    veh2_req = 1'b0; veh1_req = 1'b1;
    wait_phase(4, 60, "reach_y2");
    tick();
    do_reset();
    veh1_req = 1'b0;
    ticks(5);

    // Randomized demand, pedestrian pulses and occasional resets.
    ped_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) veh1_req = ~veh1_req;
      if ($urandom_range(7) == 0) veh2_req = ~veh2_req;
      if (ped_left > 0) ped_left--;
      else if ($urandom_range(24) == 0) ped_left = $urandom_range(3, 1);
      ped_req = (ped_left > 0);
      if ($urandom_range(599) == 0) do_reset();
      else tick();
    end
    ped_req = 1'b0;
    tick();
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
